// File: rtl/boot_rom_pkg.sv
// -----------------------------------------------------------------------------
// boot_rom_pkg
// Shared definitions for the boot ROM slice:
//   BOOT_RESP_T(W)   macro building the {err, data} response struct for any
//                    data width (packages cannot hold width-parametrised types)
//   BOOT_IMAGE       default ROM contents, four 64-bit words
//   boot_rom_resp_t  response struct at the default 64-bit width
//   ERR_DATA         data returned with an error response (all zeros)
//   log2_bytes()     number of byte-offset address bits for a word width
// -----------------------------------------------------------------------------
`ifndef BOOT_ROM_RESP_T
`define BOOT_ROM_RESP_T(W) struct packed { logic err; logic [(W)-1:0] data; }
`endif

package boot_rom_pkg;

  localparam int BOOT_WORDS     = 4;
  localparam int BOOT_WIDTH     = 64;
  localparam int MAX_DATA_WIDTH = 256;

  // Word 0 holds the reset vector entry.
  localparam logic [BOOT_WORDS-1:0][BOOT_WIDTH-1:0] BOOT_IMAGE = {
    64'hdeadbeef_cafef00d,
    64'h00028067_00000013,
    64'h00000297_0202b283,
    64'h00a2a023_45056291
  };

  localparam logic [MAX_DATA_WIDTH-1:0] ERR_DATA = '0;

  typedef `BOOT_ROM_RESP_T(BOOT_WIDTH) boot_rom_resp_t;

  function automatic int log2_bytes(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/boot_rom_resp_buf.sv
// -----------------------------------------------------------------------------
// boot_rom_resp_buf
// Generic first-word-fall-through FIFO. The head entry is always visible on
// dout_o; count_o reports occupancy (0..DEPTH) and doubles as the empty flag.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset (empties the FIFO)
//   push_i   in   write din_i at the tail
//   din_i    in   WIDTH  entry to write
//   pop_i    in   drop the head entry (ignored when empty)
//   dout_o   out  WIDTH  head entry; undefined while count_o == 0
//   count_o  out  occupancy
// -----------------------------------------------------------------------------
module boot_rom_resp_buf #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop_i && (count != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_i, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= din_i;
  end

  assign dout_o  = mem[rd_ptr];
  assign count_o = count;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/boot_rom_sync.sv
// -----------------------------------------------------------------------------
// boot_rom_sync
// Registered boot ROM on a req/gnt request channel with an rvalid/rready
// response channel. Requests are decoded at accept, travel a LATENCY-deep
// pipeline and land in a response FIFO that absorbs backpressure. A credit
// counter (pipeline + FIFO occupancy) gates gnt_o so the FIFO never overflows.
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   req_i     in   request valid
//   we_i      in   write request; always answered with an error
//   addr_i    in   64  byte address
//   gnt_o     out  request accepted this cycle
//   rvalid_o  out  response valid
//   rready_i  in   response consumed when rvalid_o && rready_i
//   rdata_o   out  DATA_WIDTH read data, zero on error or when idle
//   rerr_o    out  write, address below BASE_ADDR, or index >= DEPTH
// -----------------------------------------------------------------------------
module boot_rom_sync
  import boot_rom_pkg::*;
#(
  parameter int                            DATA_WIDTH = 64,
  parameter int                            DEPTH      = 4,
  parameter logic [63:0]                   BASE_ADDR  = 64'h1_0000,
  parameter int                            LATENCY    = 1,
  parameter int                            RESP_DEPTH = 2,
  parameter logic [DEPTH-1:0][DATA_WIDTH-1:0] INIT    = BOOT_IMAGE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [63:0]           addr_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rerr_o
);

  localparam int OFF_BITS = log2_bytes(DATA_WIDTH);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(RESP_DEPTH + 1);

  typedef `BOOT_ROM_RESP_T(DATA_WIDTH) resp_t;
  localparam int RESP_W = $bits(resp_t);

  logic [CNT_W-1:0]  outstanding;
  logic              accept;
  logic              pop;
  logic [63:0]       offset;
  logic [63:0]       index;
  logic              out_of_range;
  resp_t             dec_resp;
  logic              push_valid;
  resp_t             push_resp;
  logic [RESP_W-1:0] head_bits;
  resp_t             head;
  logic [CNT_W-1:0]  buf_count;

  // ---------------------------------------------------------------- credits
  // The registered count only sees a pop on the following cycle, so a freed
  // slot is granted one cycle after the pop, never in the same cycle.
  assign gnt_o  = req_i && !rst_i && (outstanding < CNT_W'(RESP_DEPTH));
  assign accept = req_i && gnt_o;
  assign pop    = rvalid_o && rready_i;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of the order the processes are evaluated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ----------------------------------------------------------------- decode
  // NOTE: every variable is assigned on every path through this block, so no
  // latch is inferred.
  always_comb begin
    // Unsigned 64-bit subtraction: addresses below BASE_ADDR wrap to a huge
    // offset, but are flagged separately so the check never depends on it.
    offset       = addr_i - BASE_ADDR;
    index        = offset >> OFF_BITS;
    out_of_range = (addr_i < BASE_ADDR) || (index >= 64'(DEPTH));
    dec_resp.err = we_i || out_of_range;
    dec_resp.data = dec_resp.err ? ERR_DATA[DATA_WIDTH-1:0]
                                 : INIT[index[IDX_W-1:0]];
  end

  // --------------------------------------------------------------- pipeline
  // The FIFO write is the final register of the latency pipeline, so only
  // LATENCY-1 explicit stages sit in front of it; the response is readable
  // LATENCY cycles after the accept cycle.
  if (LATENCY == 2) begin : g_lat2
    logic  s1_valid;
    resp_t s1_resp;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_valid <= 1'b0;
        s1_resp  <= '0;
      end else begin
        s1_valid <= accept;
        s1_resp  <= dec_resp;
      end
    end

    assign push_valid = s1_valid;
    assign push_resp  = s1_resp;
  end else begin : g_lat1
    assign push_valid = accept;
    assign push_resp  = dec_resp;
  end

  // ---------------------------------------------------------- response FIFO
  boot_rom_resp_buf #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_valid),
    .din_i   (push_resp),
    .pop_i   (pop),
    .dout_o  (head_bits),
    .count_o (buf_count)
  );

  assign head     = resp_t'(head_bits);
  assign rvalid_o = (buf_count != '0);
  assign rdata_o  = rvalid_o ? head.data : '0;
  assign rerr_o   = rvalid_o && head.err;

  // ------------------------------------------------------------- assertions
  a_latency: assert property (@(posedge clk_i) (LATENCY == 1) || (LATENCY == 2));
  a_resp_depth: assert property (@(posedge clk_i) RESP_DEPTH >= LATENCY);
  a_base_aligned: assert property (@(posedge clk_i)
    (BASE_ADDR & 64'((DATA_WIDTH / 8) - 1)) == 64'd0);
  a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (rvalid_o && !rready_i) |=> ($stable(rdata_o) && $stable(rerr_o)));

endmodule
